// File: rtl/pc_stack_unit_if.sv
// Bus bundle between the controller/datapath/decoder side and pc_stack_unit.
// The prev_pc debug port is present only when PC_TRACE_EN is defined.
interface pc_stack_unit_if #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic              loadpc;
    logic [1:0]        pc_sel;
    logic              cond_ok;
    logic              push_link;
    logic              msel;
    logic [DATA_W-1:0] C;
    logic [DATA_W-1:0] sximm8;

    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  stack_count;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;
`ifdef PC_TRACE_EN
    logic [ADDR_W-1:0] prev_pc;
`endif

    modport master (
        output loadpc, pc_sel, cond_ok, push_link, msel, C, sximm8,
`ifdef PC_TRACE_EN
        input  prev_pc,
`endif
        input  address, pc, stack_count, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  loadpc, pc_sel, cond_ok, push_link, msel, C, sximm8,
`ifdef PC_TRACE_EN
        output prev_pc,
`endif
        output address, pc, stack_count, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, absolute jump and call/return via a link stack.
// Define PC_TRACE_EN to add the prev_pc single-step debug register.
module pc_stack_unit #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    pc_stack_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] SEL_INC = 2'b00;
    localparam logic [1:0] SEL_REL = 2'b01;
    localparam logic [1:0] SEL_ABS = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
`ifdef PC_TRACE_EN
    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
`endif

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              full;
    logic              empty;

    assign inc      = pc_q + 1'b1;
    assign offset   = bus.sximm8[ADDR_W-1:0];
    assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);
    // Indices are only used when the guarding full/empty test allows it.
    assign top_idx  = IDX_W'(cnt_q - 1'b1);
    assign push_idx = IDX_W'(cnt_q);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stack_d = stack_q;
`ifdef PC_TRACE_EN
        prev_pc_d = prev_pc_q;
`endif
        if (bus.loadpc) begin
`ifdef PC_TRACE_EN
            prev_pc_d = pc_q;
`endif
            case (bus.pc_sel)
                SEL_INC: pc_d = inc;
                SEL_REL: pc_d = bus.cond_ok ? (inc + offset) : inc;
                SEL_ABS: pc_d = bus.C[ADDR_W-1:0];
                SEL_RET: begin
                    if (empty) begin
                        pc_d  = inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d = stack_q[top_idx];
                        // A return combined with push_link is a tail call: swap the top.
                        if (bus.push_link) stack_d[top_idx] = inc;
                        else               cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase

            if (bus.push_link && (bus.pc_sel != SEL_RET)) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    stack_d[push_idx] = inc;
                    cnt_d             = cnt_q + 1'b1;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            // NOTE: the link stack is a small flop array, so it is cleared on reset like any register.
            stack_q <= '{default: '0};
`ifdef PC_TRACE_EN
            prev_pc_q <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stack_q <= stack_d;
`ifdef PC_TRACE_EN
            prev_pc_q <= prev_pc_d;
`endif
        end
    end

    assign bus.address     = bus.msel ? bus.C[ADDR_W-1:0] : pc_q;
    assign bus.pc          = pc_q;
    assign bus.stack_count = cnt_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;
`ifdef PC_TRACE_EN
    assign bus.prev_pc     = prev_pc_q;
`endif

    // Upper bits of C and sximm8 are not part of any address computation.
    generate
        if (DATA_W > ADDR_W) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{bus.C[DATA_W-1:ADDR_W], bus.sximm8[DATA_W-1:ADDR_W]};
        end
    endgenerate
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: queue-based reference model checked every cycle
// plus hand-computed literal expectations.
module tb_pc_stack_unit;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int STACK_DEPTH = 4;
    localparam int unsigned M  = (1 << ADDR_W) - 1;

    logic clk;
    logic reset;

    pc_stack_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    pc_stack_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue whose back is the top of stack.
    int unsigned m_pc;
    int unsigned m_prev;
    int unsigned m_inc;
    int unsigned m_stk[$];
    bit          m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0;
            m_prev = 0;
            m_err = 1'b0;
            m_stk.delete();
        end else if (bus.loadpc) begin
            m_prev = m_pc;
            m_inc = (m_pc + 1) & M;
            case (bus.pc_sel)
                2'd0: m_pc = m_inc;
                2'd1: m_pc = bus.cond_ok ? ((m_inc + int'(bus.sximm8)) & M) : m_inc;
                2'd2: m_pc = int'(bus.C) & M;
                2'd3: begin
                    if (m_stk.size() == 0) begin
                        m_pc = m_inc;
                        m_err = 1'b1;
                    end else if (bus.push_link) begin
                        m_pc = m_stk[$];
                        m_stk[$] = m_inc;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
            endcase
            if (bus.push_link && bus.pc_sel != 2'd3) begin
                if (m_stk.size() == STACK_DEPTH) m_err = 1'b1;
                else m_stk.push_back(m_inc);
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("pc", 32'(bus.pc), m_pc);
            check("stack_count", 32'(bus.stack_count), m_stk.size());
            check("stack_full", 32'(bus.stack_full), 32'(m_stk.size() == STACK_DEPTH));
            check("stack_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
            check("stack_err", 32'(bus.stack_err), 32'(m_err));
            check("address", 32'(bus.address), bus.msel ? (int'(bus.C) & M) : m_pc);
`ifdef PC_TRACE_EN
            check("prev_pc", 32'(bus.prev_pc), m_prev);
`endif
        end
    end

    // Drives one cycle's inputs (called just after a rising edge), then lets one edge pass.
    task automatic cyc(input logic ld, input logic [1:0] sel, input logic co, input logic pl,
                       input logic ms, input logic [15:0] c, input logic [15:0] sx);
        bus.loadpc    = ld;
        bus.pc_sel    = sel;
        bus.cond_ok   = co;
        bus.push_link = pl;
        bus.msel      = ms;
        bus.C         = c;
        bus.sximm8    = sx;
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] c, input logic pl);
        cyc(1'b1, 2'd2, 1'b0, pl, 1'b0, c, 16'h0);
    endtask

    task automatic ret(input logic pl);
        cyc(1'b1, 2'd3, 1'b0, pl, 1'b0, 16'h0, 16'h0);
    endtask

    // Asynchronous reset pulse: asserted between edges, checked before any clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'h0);
        check("async_rst_cnt", 32'(bus.stack_count), 32'h0);
        check("async_rst_err", 32'(bus.stack_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.loadpc = 1'b0; bus.pc_sel = 2'd0; bus.cond_ok = 1'b0; bus.push_link = 1'b0;
        bus.msel = 1'b0; bus.C = '0; bus.sximm8 = '0;
        #12;
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_empty", 32'(bus.stack_empty), 32'h1);
        check("rst_full", 32'(bus.stack_full), 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Increment sequence, then reset mid-run with a live stack entry.
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            check("inc_pc", 32'(bus.pc), 32'(i));
        end
        cyc(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        check("call_inc_cnt", 32'(bus.stack_count), 32'h1);
        do_reset();
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("post_rst_pc", 32'(bus.pc), 32'h1);

        // Conditional relative branch, taken and not taken.
        jump(16'h0010, 1'b0);
        cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hFFFE);
        check("br_taken", 32'(bus.pc), 32'h0F);
        check("br_taken_model", m_pc, 32'h0F);
        jump(16'h0010, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFE);
        check("br_not_taken", 32'(bus.pc), 32'h11);

        // Call then return.
        jump(16'h0005, 1'b0);
        jump(16'h0040, 1'b1);
        check("call_pc", 32'(bus.pc), 32'h40);
        check("call_cnt", 32'(bus.stack_count), 32'h1);
        ret(1'b0);
        check("ret_pc", 32'(bus.pc), 32'h06);
        check("ret_empty", 32'(bus.stack_empty), 32'h1);

        // Five nested calls into a 4-deep stack, then unwind.
        jump(16'h0020, 1'b1);
        jump(16'h0030, 1'b1);
        jump(16'h0040, 1'b1);
        check("not_full_3", 32'(bus.stack_full), 32'h0);
        jump(16'h0050, 1'b1);
        check("full_4", 32'(bus.stack_full), 32'h1);
        check("no_err_4", 32'(bus.stack_err), 32'h0);
        jump(16'h0060, 1'b1);
        check("ovf_pc", 32'(bus.pc), 32'h60);
        check("ovf_err", 32'(bus.stack_err), 32'h1);
        check("ovf_cnt", 32'(bus.stack_count), 32'h4);
        ret(1'b0); check("lifo_0", 32'(bus.pc), 32'h41);
        ret(1'b0); check("lifo_1", 32'(bus.pc), 32'h31);
        ret(1'b0); check("lifo_2", 32'(bus.pc), 32'h21);
        ret(1'b0); check("lifo_3", 32'(bus.pc), 32'h07);
        check("lifo_model", m_pc, 32'h07);

        // Tail call swaps the top; tail call on empty underflows.
        do_reset();
        jump(16'h0030, 1'b0);
        jump(16'h0080, 1'b1);
        ret(1'b1);
        check("tail_pc", 32'(bus.pc), 32'h31);
        check("tail_cnt", 32'(bus.stack_count), 32'h1);
        ret(1'b0);
        check("tail_ret_pc", 32'(bus.pc), 32'h81);
        ret(1'b1);
        check("tail_empty_pc", 32'(bus.pc), 32'h82);
        check("tail_empty_err", 32'(bus.stack_err), 32'h1);
        check("tail_empty_cnt", 32'(bus.stack_count), 32'h0);

        // Underflow with wrap, sticky error, and loadpc=0 hold.
        do_reset();
        jump(16'h00FF, 1'b0);
        ret(1'b0);
        check("uflow_wrap_pc", 32'(bus.pc), 32'h00);
        check("uflow_err", 32'(bus.stack_err), 32'h1);
        cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'h0077, 16'h0);
        check("hold_pc", 32'(bus.pc), 32'h01);
        check("hold_cnt", 32'(bus.stack_count), 32'h0);
        check("err_sticky", 32'(bus.stack_err), 32'h1);

        // Address mux.
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h12AB, 16'h0);
        check("addr_c", 32'(bus.address), 32'hAB);
        check("addr_c_pc", 32'(bus.pc), 32'h01);
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h12AB, 16'h0);
        check("addr_pc", 32'(bus.address), 32'h01);
`ifdef PC_TRACE_EN
        cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0033, 16'h0);
        check("trace_prev", 32'(bus.prev_pc), 32'h01);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised successor to the single-width program counter in the RISC CPU.
- Holds the PC and supports increment, conditional PC-relative branch, absolute jump from the datapath C bus, and call/return through an internal LIFO link stack of configurable depth.
- Drives the RAM read/write address, selected between PC and C by msel, exactly as the current address path does.
- Sits between the controller, datapath (C), decoder (sximm8) and RAM.

Parameters:
- ADDR_W, 8, address/PC width in bits.
- DATA_W, 16, width of the C and sximm8 inputs.
- STACK_DEPTH, 4, number of link-stack entries; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- loadpc  input  1  PC update strobe; the PC changes only when this is 1.
- pc_sel  input  2  next-PC mode: 00 inc, 01 rel branch, 10 abs jump, 11 return.
- cond_ok  input  1  branch condition result; used only when pc_sel=01.
- push_link  input  1  with loadpc, pushes pc+1 onto the link stack (call).
- msel  input  1  address source: 1 selects C[ADDR_W-1:0], 0 selects pc.
- C  input  DATA_W  datapath output; provides the absolute target and the data address.
- sximm8  input  DATA_W  sign-extended branch offset.
- address  output  ADDR_W  memory address; combinational mux of pc and C.
- pc  output  ADDR_W  current program counter.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  stack_count == STACK_DEPTH.
- stack_empty  output  1  stack_count == 0.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, active-high):
  - pc=0, stack_count=0, stack_err=0, all stack entries cleared to 0.
  - address follows msel immediately.
- All PC arithmetic is modulo 2^ADDR_W. Offset used is sximm8[ADDR_W-1:0]; wrap-around is silent.
- Define inc = pc+1.
- On a clk rising edge with loadpc=1, next pc is:
  - pc_sel 00: inc.
  - pc_sel 01: if cond_ok=1, inc+sximm8[ADDR_W-1:0]; else inc.
  - pc_sel 10: C[ADDR_W-1:0].
  - pc_sel 11: top of stack, and stack_count decrements. If the stack is empty: next pc=inc, stack_err←1, count stays 0.
- push_link=1 with loadpc=1 and pc_sel≠11:
  - Not full: entry[stack_count]←inc, count+1.
  - Full: push dropped, stack_err←1, contents unchanged.
  - The PC update still occurs in both cases.
- push_link=1 with pc_sel=11 (tail call): the top entry is swapped.
  - Next pc=old top, top←inc, count unchanged.
  - If empty: treated as an underflow return (pc=inc, stack_err←1), and no push occurs.
- loadpc=0: pc and stack hold; push_link, pc_sel and cond_ok are ignored.
- stack_err clears only on reset.
- stack_full and stack_empty are decoded combinationally from stack_count.
- Latency: pc updates one edge after loadpc is sampled. address is combinational, with zero latency from msel, C and pc.
- Reset asserted mid-sequence aborts any pending update; the first edge after release uses pc=0.

Optional Feature:
- Macro PC_TRACE_EN.
- When defined, adds output prev_pc [ADDR_W-1:0]:
  - Loaded with the old pc on every loadpc edge.
  - Reset to 0.
  - Used for single-step debug display on the HEX4/HEX5 digits.
- When undefined, the port and its register are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then 3 loadpc pulses with pc_sel=00 → pc=0,1,2,3. Assert reset mid-run → pc=0 asynchronously, stack_count=0.
- pc=0x10, pc_sel=01, sximm8=0xFFFE (-2), cond_ok=1 → pc=0x0F. Same setup with cond_ok=0 → pc=0x11.
- pc=0x05, pc_sel=10 with push_link=1, C=0x0040 → pc=0x40, stack_count=1, top=0x06. Then pc_sel=11 → pc=0x06, stack_count=0, stack_empty=1.
- STACK_DEPTH=4: 5 calls → stack_full=1 after the 4th; the 5th call jumps but stack_err=1 and count=4. Then 4 returns yield the links in LIFO order.
- Return on empty stack at pc=0xFF → pc=0x00 (wrap), stack_err=1, and stack_err stays 1 after further ops until reset.
- msel=1, C=0x12AB → address=0xAB while pc is unchanged. msel=0 → address=pc. With PC_TRACE_EN, prev_pc equals the pc before each load.
